// File: rtl/scope_peak_seek.sv
// scope_peak_seek: per-trigger-window max/min/peak-to-peak/count of ADC samples; optional index outputs via SCOPE_PEAK_SEEK_IDX_EN
module scope_peak_seek #(
  parameter int DW = 12,
  parameter int CW = 20
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_tri,
  input  logic [DW-1:0] i_adc_data,
  input  logic          i_adc_valid,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [DW-1:0] o_max,
  output logic [DW-1:0] o_min,
  output logic [DW-1:0] o_pk2pk,
  output logic [CW-1:0] o_cnt,
  output logic          o_drop
`ifdef SCOPE_PEAK_SEEK_IDX_EN
  ,
  output logic [CW-1:0] o_max_idx,
  output logic [CW-1:0] o_min_idx
`endif
);
  typedef enum logic {IDLE, SEEK} state_t;
  state_t state_q;
  logic tri_q, trig, close, upd, first, max_up, min_up, load, drop_d, valid_d;
  logic [DW-1:0] run_max_q, run_max_d, run_min_q, run_min_d;
  logic [CW-1:0] run_cnt_q, run_cnt_d;
  // window statistics next-state; a trigger restarts the window with the sample of that same cycle
  always_comb begin
    trig = i_tri & ~tri_q;
    close = trig & (state_q == SEEK);
    upd = (state_q == SEEK) & i_adc_valid;
    first = run_cnt_q == '0;
    max_up = upd & (first | (i_adc_data > run_max_q));
    min_up = upd & (first | (i_adc_data < run_min_q));
    run_max_d = trig ? (i_adc_valid ? i_adc_data : '0) : max_up ? i_adc_data : run_max_q;
    run_min_d = trig ? (i_adc_valid ? i_adc_data : '0) : min_up ? i_adc_data : run_min_q;
    run_cnt_d = trig ? CW'(i_adc_valid) : upd ? (&run_cnt_q ? run_cnt_q : run_cnt_q + CW'(1)) : run_cnt_q;
    load = close & (~o_valid | i_ready);
    drop_d = close & o_valid & ~i_ready;
    valid_d = load | (o_valid & ~i_ready);
  end
  // FSM, running statistics and registered result/handshake outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      tri_q <= 1'b0;
      run_max_q <= '0;
      run_min_q <= '0;
      run_cnt_q <= '0;
      o_valid <= 1'b0;
      o_drop <= 1'b0;
      o_max <= '0;
      o_min <= '0;
      o_pk2pk <= '0;
      o_cnt <= '0;
    end else begin
      state_q <= trig ? SEEK : state_q;
      tri_q <= i_tri;
      run_max_q <= run_max_d;
      run_min_q <= run_min_d;
      run_cnt_q <= run_cnt_d;
      o_valid <= valid_d;
      o_drop <= drop_d;
      if (load) begin
        o_max <= run_max_q;
        o_min <= run_min_q;
        o_pk2pk <= run_max_q - run_min_q;
        o_cnt <= run_cnt_q;
      end
    end
  end
`ifdef SCOPE_PEAK_SEEK_IDX_EN
  logic [CW-1:0] max_idx_q, max_idx_d, min_idx_q, min_idx_d;
  // position of first occurrence of max/min; run_cnt_q is the index of the current sample
  always_comb begin
    max_idx_d = trig ? '0 : max_up ? run_cnt_q : max_idx_q;
    min_idx_d = trig ? '0 : min_up ? run_cnt_q : min_idx_q;
  end
  // index tracking and result registers, loaded alongside the other results
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      max_idx_q <= '0;
      min_idx_q <= '0;
      o_max_idx <= '0;
      o_min_idx <= '0;
    end else begin
      max_idx_q <= max_idx_d;
      min_idx_q <= min_idx_d;
      if (load) begin
        o_max_idx <= max_idx_q;
        o_min_idx <= min_idx_q;
      end
    end
  end
`endif
endmodule

// File: tb/tb_scope_peak_seek.sv
// tb_scope_peak_seek: directed checks of window statistics, handshake, drop and reset behaviour
module tb_scope_peak_seek;
  logic i_clk = 1'b0, i_rst = 1'b1, i_tri = 1'b0, i_adc_valid = 1'b0, i_ready = 1'b0;
  logic [11:0] i_adc_data = '0;
  logic o_valid, o_drop;
  logic [11:0] o_max, o_min, o_pk2pk;
  logic [19:0] o_cnt;
`ifdef SCOPE_PEAK_SEEK_IDX_EN
  logic [19:0] o_max_idx, o_min_idx;
`endif
  int total = 0, bad = 0;

  scope_peak_seek dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_tri(i_tri), .i_adc_data(i_adc_data), .i_adc_valid(i_adc_valid),
    .o_valid(o_valid), .i_ready(i_ready), .o_max(o_max), .o_min(o_min), .o_pk2pk(o_pk2pk),
    .o_cnt(o_cnt), .o_drop(o_drop)
`ifdef SCOPE_PEAK_SEEK_IDX_EN
    , .o_max_idx(o_max_idx), .o_min_idx(o_min_idx)
`endif
  );

  always #5 i_clk = ~i_clk;

  task automatic drive(input logic t, input logic v, input logic [11:0] d);
    i_tri = t;
    i_adc_valid = v;
    i_adc_data = d;
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    i_tri = 1'b0;
    i_adc_valid = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0d exp=0", o_valid); end
    total++; if (o_drop !== 1'b0) begin bad++; $display("FAIL reset_drop got=%0d exp=0", o_drop); end
    total++; if (o_max !== 12'd0) begin bad++; $display("FAIL reset_max got=%0d exp=0", o_max); end
    total++; if (o_min !== 12'd0) begin bad++; $display("FAIL reset_min got=%0d exp=0", o_min); end
    total++; if (o_pk2pk !== 12'd0) begin bad++; $display("FAIL reset_pk2pk got=%0d exp=0", o_pk2pk); end
    total++; if (o_cnt !== 20'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", o_cnt); end
    i_ready = 1'b1;
    drive(1, 0, 0);
    for (int k = 0; k < 10; k++) begin
      drive(0, 1, 12'(k * 37));
      total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL first_window_valid cyc=%0d got=%0d exp=0", k, o_valid); end
    end
  endtask

  task automatic test_basic();
    do_reset();
    i_ready = 1'b1;
    drive(1, 0, 0);
    drive(0, 1, 100);
    drive(0, 1, 4000);
    drive(0, 1, 7);
    drive(0, 1, 4000);
    drive(0, 1, 50);
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL basic_pre_valid got=%0d exp=0", o_valid); end
    drive(1, 0, 0);
    total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%0d exp=1", o_valid); end
    total++; if (o_max !== 12'd4000) begin bad++; $display("FAIL basic_max got=%0d exp=4000", o_max); end
    total++; if (o_min !== 12'd7) begin bad++; $display("FAIL basic_min got=%0d exp=7", o_min); end
    total++; if (o_pk2pk !== 12'd3993) begin bad++; $display("FAIL basic_pk2pk got=%0d exp=3993", o_pk2pk); end
    total++; if (o_cnt !== 20'd5) begin bad++; $display("FAIL basic_cnt got=%0d exp=5", o_cnt); end
`ifdef SCOPE_PEAK_SEEK_IDX_EN
    total++; if (o_max_idx !== 20'd1) begin bad++; $display("FAIL basic_max_idx got=%0d exp=1", o_max_idx); end
    total++; if (o_min_idx !== 20'd2) begin bad++; $display("FAIL basic_min_idx got=%0d exp=2", o_min_idx); end
`endif
    drive(0, 0, 0);
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL basic_after_accept_valid got=%0d exp=0", o_valid); end
    total++; if (o_drop !== 1'b0) begin bad++; $display("FAIL basic_drop got=%0d exp=0", o_drop); end
  endtask

  task automatic test_same_cycle();
    do_reset();
    i_ready = 1'b1;
    drive(1, 0, 0);
    drive(0, 1, 10);
    drive(0, 1, 20);
    drive(1, 1, 4095);
    total++; if (o_max !== 12'd20) begin bad++; $display("FAIL same_w1_max got=%0d exp=20", o_max); end
    total++; if (o_cnt !== 20'd2) begin bad++; $display("FAIL same_w1_cnt got=%0d exp=2", o_cnt); end
    drive(0, 1, 5);
    drive(1, 0, 0);
    total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL same_w2_valid got=%0d exp=1", o_valid); end
    total++; if (o_max !== 12'd4095) begin bad++; $display("FAIL same_w2_max got=%0d exp=4095", o_max); end
    total++; if (o_min !== 12'd5) begin bad++; $display("FAIL same_w2_min got=%0d exp=5", o_min); end
    total++; if (o_pk2pk !== 12'd4090) begin bad++; $display("FAIL same_w2_pk2pk got=%0d exp=4090", o_pk2pk); end
    total++; if (o_cnt !== 20'd2) begin bad++; $display("FAIL same_w2_cnt got=%0d exp=2", o_cnt); end
`ifdef SCOPE_PEAK_SEEK_IDX_EN
    total++; if (o_max_idx !== 20'd0) begin bad++; $display("FAIL same_w2_max_idx got=%0d exp=0", o_max_idx); end
    total++; if (o_min_idx !== 20'd1) begin bad++; $display("FAIL same_w2_min_idx got=%0d exp=1", o_min_idx); end
`endif
  endtask

  task automatic test_drop();
    do_reset();
    i_ready = 1'b0;
    drive(1, 0, 0);
    drive(0, 1, 300);
    drive(0, 1, 200);
    drive(1, 0, 0);
    total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL drop_pend_valid got=%0d exp=1", o_valid); end
    total++; if (o_drop !== 1'b0) begin bad++; $display("FAIL drop_early got=%0d exp=0", o_drop); end
    drive(0, 1, 1000);
    drive(1, 0, 0);
    total++; if (o_drop !== 1'b1) begin bad++; $display("FAIL drop_pulse got=%0d exp=1", o_drop); end
    total++; if (o_max !== 12'd300) begin bad++; $display("FAIL drop_held_max got=%0d exp=300", o_max); end
    total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL drop_held_valid got=%0d exp=1", o_valid); end
    drive(0, 0, 0);
    total++; if (o_drop !== 1'b0) begin bad++; $display("FAIL drop_one_cycle got=%0d exp=0", o_drop); end
    total++; if (o_min !== 12'd200) begin bad++; $display("FAIL drop_held_min got=%0d exp=200", o_min); end
    total++; if (o_cnt !== 20'd2) begin bad++; $display("FAIL drop_held_cnt got=%0d exp=2", o_cnt); end
    i_ready = 1'b1;
    drive(0, 0, 0);
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL drop_accept_valid got=%0d exp=0", o_valid); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    i_ready = 1'b0;
    drive(1, 0, 0);
    drive(0, 1, 9);
    drive(1, 0, 0);
    drive(0, 1, 50);
    drive(0, 1, 60);
    total++; if (o_max !== 12'd9) begin bad++; $display("FAIL b2b_pend_max got=%0d exp=9", o_max); end
    i_ready = 1'b1;
    drive(1, 0, 0);
    total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid got=%0d exp=1", o_valid); end
    total++; if (o_drop !== 1'b0) begin bad++; $display("FAIL b2b_drop got=%0d exp=0", o_drop); end
    total++; if (o_max !== 12'd60) begin bad++; $display("FAIL b2b_max got=%0d exp=60", o_max); end
    total++; if (o_min !== 12'd50) begin bad++; $display("FAIL b2b_min got=%0d exp=50", o_min); end
  endtask

  task automatic test_empty();
    do_reset();
    i_ready = 1'b1;
    drive(1, 0, 0);
    drive(0, 1, 777);
    drive(1, 0, 0);
    drive(0, 0, 0);
    drive(1, 0, 0);
    total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL empty_valid got=%0d exp=1", o_valid); end
    total++; if (o_cnt !== 20'd0) begin bad++; $display("FAIL empty_cnt got=%0d exp=0", o_cnt); end
    total++; if (o_max !== 12'd0) begin bad++; $display("FAIL empty_max got=%0d exp=0", o_max); end
    total++; if (o_min !== 12'd0) begin bad++; $display("FAIL empty_min got=%0d exp=0", o_min); end
    total++; if (o_pk2pk !== 12'd0) begin bad++; $display("FAIL empty_pk2pk got=%0d exp=0", o_pk2pk); end
  endtask

  task automatic test_held_and_rst();
    do_reset();
    i_ready = 1'b1;
    drive(1, 0, 0);
    for (int k = 2; k <= 20; k++) begin
      drive(1, 1, 12'(k));
      total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL held_valid k=%0d got=%0d exp=0", k, o_valid); end
    end
    drive(0, 0, 0);
    drive(1, 0, 0);
    total++; if (o_cnt !== 20'd19) begin bad++; $display("FAIL held_cnt got=%0d exp=19", o_cnt); end
    total++; if (o_max !== 12'd20) begin bad++; $display("FAIL held_max got=%0d exp=20", o_max); end
    total++; if (o_pk2pk !== 12'd18) begin bad++; $display("FAIL held_pk2pk got=%0d exp=18", o_pk2pk); end
`ifdef SCOPE_PEAK_SEEK_IDX_EN
    total++; if (o_max_idx !== 20'd18) begin bad++; $display("FAIL held_max_idx got=%0d exp=18", o_max_idx); end
`endif
    drive(0, 0, 0);
    drive(0, 1, 500);
    i_rst = 1'b1;
    drive(0, 0, 0);
    i_rst = 1'b0;
    drive(1, 0, 0);
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL rst_open_valid got=%0d exp=0", o_valid); end
    drive(0, 1, 3);
    drive(0, 0, 0);
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_valid got=%0d exp=0", o_valid); end
    drive(1, 0, 0);
    total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL rst_close_valid got=%0d exp=1", o_valid); end
    total++; if (o_cnt !== 20'd1) begin bad++; $display("FAIL rst_close_cnt got=%0d exp=1", o_cnt); end
    total++; if (o_max !== 12'd3) begin bad++; $display("FAIL rst_close_max got=%0d exp=3", o_max); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_same_cycle();
    test_drop();
    test_back_to_back();
    test_empty();
    test_held_and_rst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
